// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: ID/EX mode codes and FSM states.
package hazard_pkg;

    localparam logic [1:0] HZ_BUBBLE = 2'b00;
    localparam logic [1:0] HZ_LOAD   = 2'b01;
    localparam logic [1:0] HZ_HOLD   = 2'b10;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MC_BUSY = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard-control bundle between the pipeline datapath (master) and hazard_unit (slave).
interface hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_Rs;
    logic [4:0]       IF_ID_Rt;
    logic             ID_UsesRs;
    logic             ID_UsesRt;
    logic             ID_Jump;
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_Rt;
    logic             EX_BranchTaken;
    logic             EX_MultiCycle;
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic [1:0]       ID_EX_Hazard;
    logic             Hazard_Delay;
    logic             EX_MEM_Bubble;
    logic [CNT_W-1:0] Stall_Cnt;
    logic [CNT_W-1:0] Flush_Cnt;

    modport master (
        output IF_ID_Rs, IF_ID_Rt, ID_UsesRs, ID_UsesRt, ID_Jump,
               ID_EX_MemRead, ID_EX_Rt, EX_BranchTaken, EX_MultiCycle,
        input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Hazard,
               Hazard_Delay, EX_MEM_Bubble, Stall_Cnt, Flush_Cnt
    );

    modport slave (
        input  IF_ID_Rs, IF_ID_Rt, ID_UsesRs, ID_UsesRt, ID_Jump,
               ID_EX_MemRead, ID_EX_Rt, EX_BranchTaken, EX_MultiCycle,
        output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Hazard,
               Hazard_Delay, EX_MEM_Bubble, Stall_Cnt, Flush_Cnt
    );
endinterface

// File: rtl/hazard_unit_load_use_cmp.sv
// Combinational load-use detector; also shared with the forwarding unit's checks.
module load_use_cmp (
    input  logic       mem_read_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic       uses_rs_i,
    input  logic       uses_rt_i,
    output logic       hazard_o
);
    // $zero is never a real dependency
    assign hazard_o = mem_read_i && (ex_rt_i != 5'd0) &&
                      ((uses_rs_i && (ex_rt_i == rs_i)) ||
                       (uses_rt_i && (ex_rt_i == rt_i)));
endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/bubble controller for the 5-stage core, with multi-cycle EX hold FSM
// and saturating stall/flush event counters.
//
// state      | meaning
// ST_RUN     | normal priority evaluation of branch / multi-cycle / load-use / jump
// ST_MC_BUSY | multi-cycle op in EX; hold front of pipe until mc_cnt reaches 0
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    hazard_unit_if.slave hz
);
    localparam int              MC_W    = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam bit              MC_EN   = (MUL_LAT > 1);
    localparam logic [MC_W-1:0] MC_LOAD = MC_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

    hz_state_e        state_q, state_d;
    logic [MC_W-1:0]  mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             stall_inc, flush_inc;
    logic             load_use;
    logic             pc_write, if_id_write, if_id_flush, hazard_delay, ex_mem_bubble;
    logic [1:0]       id_ex_hazard;
    logic             releasing;

    load_use_cmp u_load_use_cmp (
        .mem_read_i (hz.ID_EX_MemRead),
        .ex_rt_i    (hz.ID_EX_Rt),
        .rs_i       (hz.IF_ID_Rs),
        .rt_i       (hz.IF_ID_Rt),
        .uses_rs_i  (hz.ID_UsesRs),
        .uses_rt_i  (hz.ID_UsesRt),
        .hazard_o   (load_use)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            mc_cnt_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
            if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        mc_cnt_d      = mc_cnt_q;
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_hazard  = HZ_BUBBLE;
        hazard_delay  = 1'b0;
        ex_mem_bubble = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        releasing     = (state_q == ST_MC_BUSY);

        if (reset) begin
            if_id_flush   = 1'b1;
            hazard_delay  = 1'b1;
            ex_mem_bubble = 1'b1;
            state_d       = ST_RUN;
        end else if (state_q == ST_MC_BUSY && mc_cnt_q != '0) begin
            id_ex_hazard  = HZ_HOLD;
            ex_mem_bubble = 1'b1;
            mc_cnt_d      = mc_cnt_q - 1'b1;
        end else begin
            // release cycle shares the RUN rules but never re-enters MC_BUSY
            state_d = ST_RUN;
            if (hz.EX_BranchTaken) begin
                pc_write     = 1'b1;
                if_id_flush  = 1'b1;
                hazard_delay = 1'b1;
                id_ex_hazard = HZ_LOAD;
                flush_inc    = 1'b1;
            end else if (MC_EN && hz.EX_MultiCycle && !releasing) begin
                id_ex_hazard  = HZ_HOLD;
                ex_mem_bubble = 1'b1;
                mc_cnt_d      = MC_LOAD;
                state_d       = ST_MC_BUSY;
            end else if (load_use) begin
                id_ex_hazard = HZ_BUBBLE;
                stall_inc    = 1'b1;
            end else if (hz.ID_Jump) begin
                pc_write     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_hazard = HZ_LOAD;
                flush_inc    = 1'b1;
            end else begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                id_ex_hazard = HZ_LOAD;
            end
        end
    end

    assign hz.PC_Write      = pc_write;
    assign hz.IF_ID_Write   = if_id_write;
    assign hz.IF_ID_Flush   = if_id_flush;
    assign hz.ID_EX_Hazard  = id_ex_hazard;
    assign hz.Hazard_Delay  = hazard_delay;
    assign hz.EX_MEM_Bubble = ex_mem_bubble;
    assign hz.Stall_Cnt     = stall_cnt_q;
    assign hz.Flush_Cnt     = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboarded bench for hazard_unit: MUL_LAT=4/CNT_W=4 main instance plus a MUL_LAT=1 instance.
module tb_hazard_unit;

    typedef logic [6:0] ctl_t;  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Hazard, Hazard_Delay, EX_MEM_Bubble}

    typedef struct packed {
        logic       br;
        logic       mc;
        logic       mr;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       jmp;
    } stim_t;

    localparam ctl_t C_NORM   = 7'b1100100;
    localparam ctl_t C_STALL  = 7'b0000000;
    localparam ctl_t C_HOLD   = 7'b0001001;
    localparam ctl_t C_BRANCH = 7'b1010110;
    localparam ctl_t C_JUMP   = 7'b1010100;
    localparam ctl_t C_RESET  = 7'b0010011;

    logic clk = 1'b0;
    logic reset_a = 1'b0;
    logic reset_b = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;
    ctl_t exp_q[$];

    always #5 clk = ~clk;

    hazard_unit_if #(.CNT_W(4))  ifa ();
    hazard_unit_if #(.CNT_W(16)) ifb ();

    hazard_unit #(.MUL_LAT(4), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset_a),
        .hz    (ifa)
    );

    hazard_unit #(.MUL_LAT(1), .CNT_W(16)) dut_lat1 (
        .clk   (clk),
        .reset (reset_b),
        .hz    (ifb)
    );

    wire ctl_t obs_a = {ifa.PC_Write, ifa.IF_ID_Write, ifa.IF_ID_Flush,
                        ifa.ID_EX_Hazard, ifa.Hazard_Delay, ifa.EX_MEM_Bubble};
    wire ctl_t obs_b = {ifb.PC_Write, ifb.IF_ID_Write, ifb.IF_ID_Flush,
                        ifb.ID_EX_Hazard, ifb.Hazard_Delay, ifb.EX_MEM_Bubble};

    function automatic stim_t mk(input logic br, input logic mc, input logic mr,
                                 input logic [4:0] ex_rt, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic urs, input logic urt, input logic jmp);
        stim_t s;
        s = '{br: br, mc: mc, mr: mr, ex_rt: ex_rt, rs: rs, rt: rt, urs: urs, urt: urt, jmp: jmp};
        return s;
    endfunction

    localparam stim_t IDLE = '0;
    localparam stim_t LU   = '{br: 1'b0, mc: 1'b0, mr: 1'b1, ex_rt: 5'd8, rs: 5'd8, rt: 5'd0,
                               urs: 1'b1, urt: 1'b0, jmp: 1'b0};

    task automatic drive(input stim_t s);
        ifa.EX_BranchTaken = s.br;
        ifa.EX_MultiCycle  = s.mc;
        ifa.ID_EX_MemRead  = s.mr;
        ifa.ID_EX_Rt       = s.ex_rt;
        ifa.IF_ID_Rs       = s.rs;
        ifa.IF_ID_Rt       = s.rt;
        ifa.ID_UsesRs      = s.urs;
        ifa.ID_UsesRt      = s.urt;
        ifa.ID_Jump        = s.jmp;
    endtask

    task automatic test_reset();
        ctl_t got, want;
        @(posedge clk); #1;
        reset_a = 1'b1;
        reset_b = 1'b1;
        drive(LU);
        exp_q.push_back(C_RESET);
        @(negedge clk);
        got = obs_a; want = exp_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b want=%b", got, want);
        end
        @(posedge clk); #1;
        reset_a = 1'b0;
        reset_b = 1'b0;
        drive(IDLE);
        exp_stall = 0; exp_flush = 0;
        exp_q.push_back(C_NORM);
        @(negedge clk);
        got = obs_a; want = exp_q.pop_front(); vectors++;
        if (got !== want || ifa.Stall_Cnt !== 4'd0 || ifa.Flush_Cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL post_reset ctl=%b want=%b stall=%0d flush=%0d want 0/0",
                     got, want, ifa.Stall_Cnt, ifa.Flush_Cnt);
        end
    endtask

    task automatic test_load_use();
        stim_t s[6];
        ctl_t  e[6];
        ctl_t  got, want;
        s[0] = LU;                                   e[0] = C_STALL;
        s[1] = mk(0, 0, 1, 0, 0, 0, 1, 0, 0);        e[1] = C_NORM;
        s[2] = mk(0, 0, 1, 9, 3, 9, 1, 1, 0);        e[2] = C_STALL;
        s[3] = mk(0, 0, 1, 8, 8, 0, 0, 0, 0);        e[3] = C_NORM;
        s[4] = mk(0, 0, 0, 8, 8, 8, 1, 1, 0);        e[4] = C_NORM;
        s[5] = mk(0, 0, 1, 12, 12, 12, 0, 1, 0);     e[5] = C_STALL;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = obs_a; want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL load_use[%0d] got=%b want=%b", i, got, want);
            end
        end
        exp_stall += 3;
        @(posedge clk); #1;
        drive(IDLE);
        @(negedge clk);
        vectors++;
        if (ifa.Stall_Cnt !== 4'(exp_stall) || ifa.Flush_Cnt !== 4'(exp_flush)) begin
            miscompares++;
            $display("FAIL load_use_cnt stall=%0d flush=%0d want %0d/%0d",
                     ifa.Stall_Cnt, ifa.Flush_Cnt, exp_stall, exp_flush);
        end
    endtask

    task automatic test_branch_over_load_use();
        ctl_t got, want;
        stim_t s;
        s = LU;
        s.br = 1'b1;
        @(posedge clk); #1;
        drive(s);
        exp_q.push_back(C_BRANCH);
        @(negedge clk);
        got = obs_a; want = exp_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL branch_over_lu got=%b want=%b", got, want);
        end
        exp_flush++;
        @(posedge clk); #1;
        drive(IDLE);
        exp_q.push_back(C_NORM);
        @(negedge clk);
        got = obs_a; want = exp_q.pop_front(); vectors++;
        if (got !== want || ifa.Flush_Cnt !== 4'(exp_flush) || ifa.Stall_Cnt !== 4'(exp_stall)) begin
            miscompares++;
            $display("FAIL branch_cnt ctl=%b want=%b flush=%0d stall=%0d want %0d/%0d",
                     got, want, ifa.Flush_Cnt, ifa.Stall_Cnt, exp_flush, exp_stall);
        end
    endtask

    task automatic test_multicycle();
        stim_t s[11];
        ctl_t  e[11];
        ctl_t  got, want;
        stim_t rel_lu;
        rel_lu = LU;
        rel_lu.mc = 1'b1;
        s[0] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);  e[0] = C_HOLD;
        s[1] = s[0];                           e[1] = C_HOLD;
        s[2] = s[0];                           e[2] = C_HOLD;
        s[3] = s[0];                           e[3] = C_NORM;
        s[4] = IDLE;                           e[4] = C_NORM;
        s[5] = s[0];                           e[5] = C_HOLD;
        s[6] = s[0];                           e[6] = C_HOLD;
        s[7] = s[0];                           e[7] = C_HOLD;
        s[8] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1);  e[8] = C_JUMP;
        s[9] = s[0];                           e[9] = C_HOLD;
        s[10] = IDLE;                          e[10] = C_HOLD;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = obs_a; want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL multicycle[%0d] got=%b want=%b", i, got, want);
            end
        end
        exp_flush++;
        // third op: release cycle coincides with a load-use
        @(posedge clk); #1;
        drive(IDLE);
        @(posedge clk); #1;
        drive(rel_lu);
        exp_q.push_back(C_STALL);
        @(negedge clk);
        got = obs_a; want = exp_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL mc_release_lu got=%b want=%b", got, want);
        end
        exp_stall++;
        @(posedge clk); #1;
        drive(IDLE);
        @(negedge clk);
        vectors++;
        if (ifa.Stall_Cnt !== 4'(exp_stall) || ifa.Flush_Cnt !== 4'(exp_flush)) begin
            miscompares++;
            $display("FAIL multicycle_cnt stall=%0d flush=%0d want %0d/%0d",
                     ifa.Stall_Cnt, ifa.Flush_Cnt, exp_stall, exp_flush);
        end
    endtask

    task automatic test_reset_mid_busy();
        ctl_t got, want;
        @(posedge clk); #1;
        drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(C_HOLD);
        @(negedge clk);
        got = obs_a; want = exp_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL mid_busy_entry got=%b want=%b", got, want);
        end
        @(posedge clk); #1;
        reset_a = 1'b1;
        exp_q.push_back(C_RESET);
        @(negedge clk);
        got = obs_a; want = exp_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL mid_busy_reset got=%b want=%b", got, want);
        end
        @(posedge clk); #1;
        reset_a = 1'b0;
        drive(IDLE);
        exp_stall = 0; exp_flush = 0;
        exp_q.push_back(C_NORM);
        @(negedge clk);
        got = obs_a; want = exp_q.pop_front(); vectors++;
        if (got !== want || ifa.Stall_Cnt !== 4'd0 || ifa.Flush_Cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL mid_busy_after ctl=%b want=%b stall=%0d flush=%0d want 0/0",
                     got, want, ifa.Stall_Cnt, ifa.Flush_Cnt);
        end
    endtask

    task automatic test_jump_load_use();
        ctl_t got, want;
        stim_t s;
        s = LU;
        s.jmp = 1'b1;
        @(posedge clk); #1;
        drive(s);
        exp_q.push_back(C_STALL);
        @(negedge clk);
        got = obs_a; want = exp_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL jump_lu_stall got=%b want=%b", got, want);
        end
        exp_stall++;
        @(posedge clk); #1;
        s.mr = 1'b0;
        drive(s);
        exp_q.push_back(C_JUMP);
        @(negedge clk);
        got = obs_a; want = exp_q.pop_front(); vectors++;
        if (got !== want || ifa.Stall_Cnt !== 4'(exp_stall) || ifa.Flush_Cnt !== 4'(exp_flush)) begin
            miscompares++;
            $display("FAIL jump_after_stall ctl=%b want=%b stall=%0d flush=%0d want %0d/%0d",
                     got, want, ifa.Stall_Cnt, ifa.Flush_Cnt, exp_stall, exp_flush);
        end
        exp_flush++;
        @(posedge clk); #1;
        drive(IDLE);
        @(negedge clk);
        vectors++;
        if (ifa.Flush_Cnt !== 4'(exp_flush)) begin
            miscompares++;
            $display("FAIL jump_flush_cnt got=%0d want=%0d", ifa.Flush_Cnt, exp_flush);
        end
    endtask

    task automatic test_saturation();
        int want_cnt;
        @(posedge clk); #1;
        reset_a = 1'b1;
        @(posedge clk); #1;
        reset_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(LU);
            exp_q.push_back(C_STALL);
            @(negedge clk);
            want_cnt = (i > 15) ? 15 : i;
            vectors++;
            if (obs_a !== exp_q.pop_front() || ifa.Stall_Cnt !== 4'(want_cnt)) begin
                miscompares++;
                $display("FAIL saturation[%0d] ctl=%b stall=%0d want stall=%0d",
                         i, obs_a, ifa.Stall_Cnt, want_cnt);
            end
            @(posedge clk); #1;
        end
        drive(IDLE);
        @(negedge clk);
        vectors++;
        if (ifa.Stall_Cnt !== 4'd15 || ifa.Flush_Cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL saturation_hold stall=%0d flush=%0d want 15/0", ifa.Stall_Cnt, ifa.Flush_Cnt);
        end
    endtask

    task automatic test_mul_lat_one();
        ctl_t got;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            ifb.EX_MultiCycle = 1'b1;
            exp_q.push_back(C_NORM);
            @(negedge clk);
            got = obs_b; vectors++;
            if (got !== exp_q.pop_front()) begin
                miscompares++;
                $display("FAIL mul_lat1[%0d] got=%b want=%b", i, got, C_NORM);
            end
        end
        ifb.EX_MultiCycle = 1'b0;
    endtask

    initial begin
        drive(IDLE);
        ifb.EX_BranchTaken = 1'b0;
        ifb.EX_MultiCycle  = 1'b0;
        ifb.ID_EX_MemRead  = 1'b0;
        ifb.ID_EX_Rt       = 5'd0;
        ifb.IF_ID_Rs       = 5'd0;
        ifb.IF_ID_Rt       = 5'd0;
        ifb.ID_UsesRs      = 1'b0;
        ifb.ID_UsesRt      = 1'b0;
        ifb.ID_Jump        = 1'b0;

        test_reset();
        test_load_use();
        test_branch_over_load_use();
        test_multicycle();
        test_reset_mid_busy();
        test_jump_load_use();
        test_saturation();
        test_mul_lat_one();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
